// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with write-first bypass, an optional
// hard-wired zero register and a sequential bulk-clear engine.
module regfile_2r1w #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 4,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re_a,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  output logic          rvalid_a,
  input  logic          re_b,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  output logic          rvalid_b,
  input  logic          clr_req,
  output logic          busy
);

  localparam int unsigned DEPTH    = 2 ** AW;
  localparam int          NumPorts = 2;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e        state_q;
  logic          busy_q;
  logic [AW-1:0] ptr_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic          zero_wr;
  logic          wr_en;

  // Writes to the hard-wired zero entry never reach the array.
  assign zero_wr = (ZERO_R0 != 0) && (waddr == '0);
  assign wr_en   = cs && we && !busy_q && !zero_wr;

  // Clear engine; busy is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q <= StClear;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        StClear: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StClear) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  logic [AW-1:0] raddr    [NumPorts];
  logic          rd_en    [NumPorts];
  logic [DW-1:0] rdata_d  [NumPorts];
  logic [DW-1:0] rdata_q  [NumPorts];
  logic          rvalid_q [NumPorts];

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;
  assign rd_en[0] = cs && re_a && !busy_q;
  assign rd_en[1] = cs && re_b && !busy_q;

  // Zero register takes priority, then the same-cycle write, then the array.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rdata_d[p] = mem_q[raddr[p]];
      if ((ZERO_R0 != 0) && (raddr[p] == '0)) begin
        rdata_d[p] = '0;
      end else if (wr_en && (waddr == raddr[p])) begin
        rdata_d[p] = wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NumPorts; p++) begin
        rdata_q[p]  <= '0;
        rvalid_q[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        rvalid_q[p] <= rd_en[p];
        if (rd_en[p]) begin
          rdata_q[p] <= rdata_d[p];
        end
      end
    end
  end

  assign rdata_a  = rdata_q[0];
  assign rvalid_a = rvalid_q[0];
  assign rdata_b  = rdata_q[1];
  assign rvalid_b = rvalid_q[1];
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: two instances (zero register on/off) share
// stimulus and are checked every cycle against an array-based model.
module tb_regfile_2r1w;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          cs      = 1'b0;
  logic          we      = 1'b0;
  logic [AW-1:0] waddr   = '0;
  logic [DW-1:0] wdata   = '0;
  logic          re_a    = 1'b0;
  logic [AW-1:0] raddr_a = '0;
  logic          re_b    = 1'b0;
  logic [AW-1:0] raddr_b = '0;
  logic          clr_req = 1'b0;

  logic [DW-1:0] rdata_a1, rdata_b1, rdata_a0, rdata_b0;
  logic          rvalid_a1, rvalid_b1, rvalid_a0, rvalid_b0;
  logic          busy1, busy0;

  always #5 clk = ~clk;

  regfile_2r1w #(.DW(DW), .AW(AW), .ZERO_R0(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
    .clr_req(clr_req), .busy(busy1)
  );

  regfile_2r1w #(.DW(DW), .AW(AW), .ZERO_R0(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
    .clr_req(clr_req), .busy(busy0)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: [z] is the instance (1 = zero register), [p] the read port.
  // A clear is modelled as wiping the whole file at once plus a busy countdown.
  logic [DW-1:0] m_mem    [2][DEPTH];
  logic [DW-1:0] m_rdata  [2][2];
  logic          m_rvalid [2];
  int            busy_left;

  always @(posedge clk or negedge rst_n) begin : model
    logic          acc;
    logic [AW-1:0] ra [2];
    logic          re [2];
    if (!rst_n) begin
      for (int z = 0; z < 2; z++) begin
        for (int i = 0; i < DEPTH; i++) m_mem[z][i] = '0;
        for (int p = 0; p < 2; p++) m_rdata[z][p] = '0;
      end
      m_rvalid[0] = 1'b0;
      m_rvalid[1] = 1'b0;
      busy_left   = 0;
    end else begin
      acc   = cs && (busy_left == 0);
      ra[0] = raddr_a;
      ra[1] = raddr_b;
      re[0] = re_a;
      re[1] = re_b;
      for (int z = 0; z < 2; z++) begin
        for (int p = 0; p < 2; p++) begin
          if (acc && re[p]) begin
            if (z == 1 && ra[p] == '0) m_rdata[z][p] = '0;
            else if (we && waddr == ra[p]) m_rdata[z][p] = wdata;
            else m_rdata[z][p] = m_mem[z][ra[p]];
          end
        end
      end
      m_rvalid[0] = acc && re[0];
      m_rvalid[1] = acc && re[1];
      for (int z = 0; z < 2; z++) begin
        if (acc && we && !(z == 1 && waddr == '0)) m_mem[z][waddr] = wdata;
      end
      if (busy_left > 0) begin
        busy_left--;
      end else if (clr_req) begin
        busy_left = DEPTH;
        for (int z = 0; z < 2; z++)
          for (int i = 0; i < DEPTH; i++) m_mem[z][i] = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc rdata_a zr1", rdata_a1, m_rdata[1][0]);
      check("cyc rdata_b zr1", rdata_b1, m_rdata[1][1]);
      check("cyc rdata_a zr0", rdata_a0, m_rdata[0][0]);
      check("cyc rdata_b zr0", rdata_b0, m_rdata[0][1]);
      check("cyc rvalid_a zr1", 32'(rvalid_a1), 32'(m_rvalid[0]));
      check("cyc rvalid_b zr1", 32'(rvalid_b1), 32'(m_rvalid[1]));
      check("cyc rvalid_a zr0", 32'(rvalid_a0), 32'(m_rvalid[0]));
      check("cyc rvalid_b zr0", 32'(rvalid_b0), 32'(m_rvalid[1]));
      check("cyc busy zr1", 32'(busy1), 32'(busy_left != 0));
      check("cyc busy zr0", 32'(busy0), 32'(busy_left != 0));
    end
  end

  task automatic step(input logic c, input logic w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic ea, input logic [AW-1:0] a,
                      input logic eb, input logic [AW-1:0] b, input logic clr);
    cs      = c;
    we      = w;
    waddr   = wa;
    wdata   = wd;
    re_a    = ea;
    raddr_a = a;
    re_b    = eb;
    raddr_b = b;
    clr_req = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int busy_cycles;
    int guard;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    check("reset rdata_a", rdata_a1, 32'h0);
    check("reset rvalid_b", 32'(rvalid_b1), 32'h0);
    check("reset busy", 32'(busy1), 32'h0);

    // Plain write then dual read of the same address.
    step(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b1, 4'd5, 1'b0);
    check("t1 rdata_a", rdata_a1, 32'hDEADBEEF);
    check("t1 rdata_b", rdata_b1, 32'hDEADBEEF);
    check("t1 rvalid_a", 32'(rvalid_a1), 32'h1);
    check("t1 rvalid_b", 32'(rvalid_b1), 32'h1);

    // Write-first bypass; port B idle holds its data.
    step(1'b1, 1'b1, 4'd7, 32'h12345678, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0);
    check("t2 bypass rdata_a", rdata_a1, 32'h12345678);
    check("t2 rvalid_b idle", 32'(rvalid_b1), 32'h0);
    check("t2 rdata_b hold", rdata_b1, 32'hDEADBEEF);

    // Zero register on vs off.
    step(1'b1, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0);
    check("t3 zr1 rdata_b", rdata_b1, 32'h0);
    check("t3 zr1 rvalid_b", 32'(rvalid_b1), 32'h1);
    check("t3 zr0 rdata_b", rdata_b0, 32'hFFFFFFFF);

    // Fill, then bulk clear with a read serviced in the request cycle.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b1, AW'(i), DW'(i + 1), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1);
    check("t4 read in clr cycle", rdata_a1, 32'h4);
    busy_cycles = 0;
    guard = 0;
    while (busy1 && guard < 40) begin
      busy_cycles++;
      guard++;
      step(1'b1, 1'b1, 4'd9, 32'h99, 1'b1, 4'd3, 1'b1, 4'd9, 1'b1);
      check("t4 rvalid_a while busy", 32'(rvalid_a1), 32'h0);
    end
    check("t4 busy cycles", 32'(busy_cycles), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, AW'(i), 1'b1, AW'(DEPTH - 1 - i), 1'b0);
      check("t4 cleared rdata_a zr0", rdata_a0, 32'h0);
      check("t4 cleared rvalid_a", 32'(rvalid_a1), 32'h1);
    end

    // Reset during a clear.
    step(1'b1, 1'b1, 4'd9, 32'h5A5A5A5A, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0);
    check("t5 pre rdata_a", rdata_a1, 32'h5A5A5A5A);
    step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
    repeat (5) idle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 rst busy", 32'(busy1), 32'h0);
    check("t5 rst rdata_a", rdata_a1, 32'h0);
    check("t5 rst rvalid_a", 32'(rvalid_a1), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 1'b1, 4'd9, 1'b0);
    check("t5 addr15 zero", rdata_a1, 32'h0);
    check("t5 addr9 zero", rdata_b1, 32'h0);
    step(1'b1, 1'b1, 4'd3, 32'hCAFE0003, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check("t5 no rvalid on write", 32'(rvalid_a1), 32'h0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
    check("t5 addr3 rdata_a", rdata_a1, 32'hCAFE0003);
    check("t5 addr3 rvalid_a", 32'(rvalid_a1), 32'h1);

    // Deselected write and read have no effect.
    step(1'b0, 1'b1, 4'd2, 32'hAA, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
    check("t6 cs0 rvalid_a", 32'(rvalid_a1), 32'h0);
    step(1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
    check("t6 addr2 unchanged", rdata_a1, 32'h0);
    check("t6 addr2 rvalid", 32'(rvalid_a1), 32'h1);

    idle();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised, multi-ported successor to the 16x16 single-port register bank.
- Provides one write port and two independent registered read ports, with write-to-read bypass and an optional hard-wired zero register.
- Adds a sequential bulk-clear engine so software/control logic can wipe the file without a global reset.
- Sits between the decode stage (read operands) and writeback (result write) of the RISC datapath.

Parameters:
- DW, 32, data width of each entry in bits.
- AW, 4, address width; DEPTH = 2**AW entries.
- ZERO_R0, 1, when 1, entry 0 always reads as 0 and writes to address 0 are discarded.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cs  input  1  block select; when 0, no read or write takes effect.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  DW  write data.
- re_a  input  1  read enable, port A.
- raddr_a  input  AW  read address, port A.
- rdata_a  output  DW  registered read data, port A.
- rvalid_a  output  1  rdata_a updated by a read accepted in the previous cycle.
- re_b  input  1  read enable, port B.
- raddr_b  input  AW  read address, port B.
- rdata_b  output  DW  registered read data, port B.
- rvalid_b  output  1  rdata_b updated by a read accepted in the previous cycle.
- clr_req  input  1  request a bulk clear of all entries.
- busy  output  1  clear engine active; all accesses are ignored.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all DEPTH entries = 0.
  - rdata_a = rdata_b = 0; rvalid_a = rvalid_b = 0.
  - busy = 0; FSM = IDLE; clear pointer = 0.
- Write:
  - Occurs on the rising edge when cs & we & ~busy: mem[waddr] <= wdata.
  - If ZERO_R0=1 and waddr=0, the write is dropped.
- Read, per port X in {a, b}:
  - Accepted on the rising edge when cs & re_X & ~busy.
  - Latency 1 cycle. rdata_X <= value; rvalid_X <= 1.
  - Value is 0 if ZERO_R0=1 and raddr_X=0.
  - Otherwise, if an effective write hits the same address in the same cycle, value = wdata (write-first bypass).
  - Otherwise value = mem[raddr_X].
  - When no read is accepted: rvalid_X <= 0 and rdata_X holds its previous value.
- Ports A and B are fully independent. Both may read the same address in the same cycle, and both receive identical data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: busy=0. clr_req=1 at a rising edge -> CLEAR, pointer=0.
    - A write or read presented in that same cycle is still performed or serviced normally.
    - A written entry is subsequently zeroed by the clear.
  - CLEAR: busy=1. Each cycle mem[pointer] <= 0 and pointer increments.
    - When pointer = DEPTH-1, that entry is cleared and the FSM returns to IDLE with busy=0 on the next cycle.
    - Total busy duration: exactly DEPTH cycles.
  - clr_req while in CLEAR is ignored; there is no queuing or restart.
  - All writes and reads while busy=1 are ignored, and rvalid_a/rvalid_b stay 0.
  - cs does not gate clr_req.
- Reset asserted mid-clear aborts the clear. The file is zeroed by reset regardless and the FSM returns to IDLE.
- Pointer wrap: AW-bit counter; it reaches DEPTH-1 without overflow into the next state.

Test Plan:
1. Reset, then write 0xDEADBEEF to addr 5. Next cycle read A=5, B=5 -> one cycle later rdata_a = rdata_b = 0xDEADBEEF, rvalid_a = rvalid_b = 1.
2. Same-cycle write addr 7 = 0x12345678 with read A=7 (stale content 0) -> next cycle rdata_a = 0x12345678 (bypass).
3. ZERO_R0=1: write 0xFFFFFFFF to addr 0, then read B=0 -> rdata_b = 0, rvalid_b = 1. With ZERO_R0=0, same sequence -> rdata_b = 0xFFFFFFFF.
4. Fill all 16 entries with i+1, then pulse clr_req:
   - busy is high for exactly 16 cycles.
   - Reads issued during busy give rvalid = 0.
   - After busy falls, reads of addrs 0..15 all return 0.
5. Start a clear, assert rst_n=0 asynchronously at clear cycle 6:
   - busy, rvalid, and rdata go to 0 immediately.
   - After release, reads of addr 15 return 0 and a new write/read to addr 3 succeeds with 1-cycle latency.
6. cs=0 with we=1 to addr 2 = 0xAA, then read addr 2 with cs=1 -> returns previous content (0), and no write occurred.
